noc_credit_link_tx: RTL and testbench

Credit-based flit transmitter for one router-to-router link. Accepts a valid/ready flit stream (data, dest, tail) and drives the link protocol (data_out, dest_out, is_tail_out, send_out), tracking downstream input-buffer space from returned credit_in pulses. It sits on the sending side of any router output or shim output, and never over-runs the FLIT_BUFFER_DEPTH buffer at the far end. It also tracks packet framing and flags protocol errors.

---
 rtl/noc_credit_link_tx.sv | 148 ++++++++++++++
 tb/tb_noc_credit_link_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_credit_link_tx.sv
// Credit-based flit transmitter for one router-to-router link.
// Forwards a valid/ready flit stream onto the link with one cycle of latency.
// It never sends more flits than the downstream buffer has returned credits for.
// It also tracks packet framing and raises sticky protocol error flags.
module noc_credit_link_tx #(
    parameter int FLIT_WIDTH        = 32,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk_noc,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FLIT_WIDTH-1:0]   in_data,
    input  logic [DEST_WIDTH-1:0]   in_dest,
    input  logic                    in_is_tail,
    output logic [FLIT_WIDTH-1:0]   data_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    output logic                    is_tail_out,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credits_avail,
    output logic                    in_packet,
    output logic                    err_credit_overflow,
    output logic                    err_dest_change
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX  = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE  = {{(CREDIT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_ZERO = {CREDIT_WIDTH{1'b0}};

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CREDIT_WIDTH-1:0] credits_r;
    logic [CREDIT_WIDTH-1:0] credits_nxt_s;
    logic [DEST_WIDTH-1:0]   pkt_dest_r;
    logic [DEST_WIDTH-1:0]   pkt_dest_nxt_s;
    logic                    fire_s;
    logic                    ovf_s;
    logic                    dest_err_s;

    // Ready depends only on the registered count, so credit_in never reaches in_ready in the same cycle.
    assign in_ready      = (credits_r != CREDIT_ZERO);
    assign fire_s        = in_valid & in_ready;
    assign credits_avail = credits_r;
    assign in_packet     = (state_r == BODY);

    // Next credit count: minus one per flit sent, plus one per credit returned, saturating at full.
    always_comb begin
        credits_nxt_s = credits_r;
        ovf_s         = 1'b0;
        case ({fire_s, credit_in})
            2'b10: begin
                credits_nxt_s = credits_r - CREDIT_ONE;
            end
            2'b01: begin
                if (credits_r == CREDIT_MAX) begin
                    ovf_s = 1'b1;
                end else begin
                    credits_nxt_s = credits_r + CREDIT_ONE;
                end
            end
            default: begin
                credits_nxt_s = credits_r;
            end
        endcase
    end

    // Packet framing FSM: next state, captured head destination, destination-change detection.
    always_comb begin
        state_nxt_s    = state_r;
        pkt_dest_nxt_s = pkt_dest_r;
        dest_err_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (fire_s && !in_is_tail) begin
                    state_nxt_s    = BODY;
                    pkt_dest_nxt_s = in_dest;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BODY: begin
                if (fire_s) begin
                    dest_err_s = (in_dest != pkt_dest_r);
                    if (in_is_tail) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = BODY;
                    end
                end else begin
                    state_nxt_s = BODY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Credit counter and sticky error flags.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            credits_r           <= CREDIT_MAX;
            err_credit_overflow <= 1'b0;
            err_dest_change     <= 1'b0;
        end else begin
            credits_r           <= credits_nxt_s;
            err_credit_overflow <= err_credit_overflow | ovf_s;
            err_dest_change     <= err_dest_change | dest_err_s;
        end
    end

    // Framing state register.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pkt_dest_r <= {DEST_WIDTH{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            pkt_dest_r <= pkt_dest_nxt_s;
        end
    end

    // Link output registers: capture the flit on a fire; otherwise hold the payload and drop send_out.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            data_out    <= {FLIT_WIDTH{1'b0}};
            dest_out    <= {DEST_WIDTH{1'b0}};
            is_tail_out <= 1'b0;
            send_out    <= 1'b0;
        end else if (fire_s) begin
            data_out    <= in_data;
            dest_out    <= in_dest;
            is_tail_out <= in_is_tail;
            send_out    <= 1'b1;
        end else begin
            send_out    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_noc_credit_link_tx.sv
// Testbench for noc_credit_link_tx: a reference model predicts credits, framing and errors.
// Predicted flits go into a queue that an independent link monitor drains.
module tb_noc_credit_link_tx;

    localparam int FW    = 32;
    localparam int DW    = 6;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_noc = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] in_data = '0;
    logic [DW-1:0] in_dest = '0;
    logic          in_is_tail = 1'b0;
    logic [FW-1:0] data_out;
    logic [DW-1:0] dest_out;
    logic          is_tail_out;
    logic          send_out;
    logic          credit_in = 1'b0;
    logic [CW-1:0] credits_avail;
    logic          in_packet;
    logic          err_credit_overflow;
    logic          err_dest_change;

    noc_credit_link_tx #(
        .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk_noc(clk_noc), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .in_is_tail(in_is_tail),
        .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
        .send_out(send_out), .credit_in(credit_in),
        .credits_avail(credits_avail), .in_packet(in_packet),
        .err_credit_overflow(err_credit_overflow), .err_dest_change(err_dest_change)
    );

    always #5 clk_noc = ~clk_noc;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, derived directly from the link rules.
    int            m_credits;
    bit            m_inpkt;
    bit [DW-1:0]   m_pdest;
    bit            m_err_ovf;
    bit            m_err_dest;
    logic [FW+DW:0] exp_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credits  = DEPTH;
        m_inpkt    = 1'b0;
        m_pdest    = '0;
        m_err_ovf  = 1'b0;
        m_err_dest = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: every flit seen on the link must be the oldest one the model predicted.
    initial begin
        logic [FW+DW:0] e;
        forever begin
            @(negedge clk_noc);
            if (rst_n && send_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_send", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("link_flit", {data_out, dest_out, is_tail_out}, e);
                end
            end
        end
    end

    // One clock of stimulus; the model decides whether the flit fires and then checks state.
    task automatic drive(input bit v, input bit [FW-1:0] d, input bit [DW-1:0] de,
                         input bit t, input bit cr, output bit fired);
        @(negedge clk_noc);
        in_valid   = v;
        in_data    = d;
        in_dest    = de;
        in_is_tail = t;
        credit_in  = cr;
        #1;
        chk("in_ready", in_ready, (m_credits != 0));
        fired = v && (m_credits != 0);
        if (fired) exp_q.push_back({d, de, t});
        if (cr && !fired && m_credits == DEPTH) m_err_ovf = 1'b1;
        else m_credits = m_credits - int'(fired) + int'(cr);
        if (fired) begin
            if (!m_inpkt) begin
                if (!t) begin
                    m_inpkt = 1'b1;
                    m_pdest = de;
                end
            end else begin
                if (de != m_pdest) m_err_dest = 1'b1;
                if (t) m_inpkt = 1'b0;
            end
        end
        @(posedge clk_noc);
        #1;
        in_valid  = 1'b0;
        credit_in = 1'b0;
        chk("credits_avail", credits_avail, m_credits);
        chk("in_packet", in_packet, m_inpkt);
        chk("err_credit_overflow", err_credit_overflow, m_err_ovf);
        chk("err_dest_change", err_dest_change, m_err_dest);
    endtask

    task automatic do_reset();
        @(negedge clk_noc);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        credit_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_noc);
        #1;
        chk("rst_credits", credits_avail, DEPTH);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_send_out", send_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_in_packet", in_packet, 0);
        chk("rst_err_ovf", err_credit_overflow, 0);
        chk("rst_err_dest", err_dest_change, 0);
        @(negedge clk_noc);
        rst_n = 1'b1;
    endtask

    initial begin
        bit f;
        bit p_v, p_t, p_pend;
        bit [FW-1:0] p_d;
        bit [DW-1:0] p_de;
        model_reset();

        // Reset state
        do_reset();

        // Burst to empty, then one credit releases the held fifth flit
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h10 + i, 6'h01, 1'b1, 1'b0, f);
        drive(1'b1, 32'h14, 6'h01, 1'b1, 1'b0, f);
        chk("burst_blocked", f, 0);
        drive(1'b1, 32'h14, 6'h01, 1'b1, 1'b1, f);
        chk("burst_credit_same_cycle", f, 0);
        drive(1'b1, 32'h14, 6'h01, 1'b1, 1'b0, f);
        chk("burst_resume", f, 1);
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0, f);

        // Simultaneous fire and credit at two credits
        do_reset();
        drive(1'b1, 32'hA0, 6'h02, 1'b1, 1'b0, f);
        drive(1'b1, 32'hA1, 6'h02, 1'b1, 1'b0, f);
        drive(1'b1, 32'hA2, 6'h02, 1'b1, 1'b1, f);
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0, f);

        // Credit overflow is sticky through later traffic
        do_reset();
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b1, f);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'hB0 + i, 6'h03, 1'b1, 1'b0, f);
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0, f);

        // Packet framing: clean packet, then one with a changed body destination
        do_reset();
        drive(1'b1, 32'hC0, 6'h05, 1'b0, 1'b0, f);
        drive(1'b1, 32'hC1, 6'h05, 1'b0, 1'b0, f);
        drive(1'b1, 32'hC2, 6'h05, 1'b1, 1'b0, f);
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b1, f);
        drive(1'b1, 32'hD0, 6'h05, 1'b0, 1'b1, f);
        drive(1'b1, 32'hD1, 6'h06, 1'b0, 1'b1, f);
        drive(1'b1, 32'hD2, 6'h05, 1'b1, 1'b1, f);
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0, f);

        // Mid-packet reset clears state immediately
        do_reset();
        drive(1'b1, 32'hE0, 6'h07, 1'b0, 1'b0, f);
        @(negedge clk_noc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_packet", in_packet, 0);
        chk("midrst_credits", credits_avail, DEPTH);
        chk("midrst_send_out", send_out, 0);
        model_reset();
        do_reset();

        // Randomized traffic with legal credit returns and held stalled flits
        p_pend = 1'b0;
        p_v = 1'b0; p_t = 1'b0; p_d = '0; p_de = '0;
        for (int c = 0; c < 400; c++) begin
            if (!p_pend) begin
                p_v = ($urandom_range(0, 3) != 0);
                p_d = $urandom;
                p_t = ($urandom_range(0, 2) == 0);
                if (m_inpkt && $urandom_range(0, 15) != 0) p_de = m_pdest;
                else p_de = DW'($urandom);
            end
            drive(p_v, p_d, p_de, p_t, (m_credits < DEPTH) && ($urandom_range(0, 1) == 1), f);
            p_pend = p_v && !f;
        end
        repeat (3) drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0, f);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
